pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, control-FSM state encoding, hazard defaults.
// Latency: n/a (types and constants only); backpressure: n/a.
package pipeline_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam int DEFAULT_LOAD_STALL_CYCLES = 2;
    localparam int STALL_CNT_W               = 3;

    typedef enum logic [1:0] {
        CS_RUN    = 2'b00,
        CS_STALL  = 2'b01,
        CS_FREEZE = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clr has priority over inc.
// Latency: 1 cycle; backpressure: none, holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush/freeze controller with performance counters.
// Latency: 0 (control outputs combinational); backpressure: mem_busy freezes every stage.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = DEFAULT_LOAD_STALL_CYCLES,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs2,
    input  logic             ID_EX_memread,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pc_sel,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_count
);

    ctrl_state_t            state;
    logic [STALL_CNT_W-1:0] stall_left;
    logic                   hazard;
    logic                   branch;
    logic                   stalling;

    assign hazard = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == ID_rs1) || (ID_uses_rs2 && (ID_EX_rd == ID_rs2)));

    assign branch   = !mem_busy && EX_branch_taken;
    assign stalling = !mem_busy && !EX_branch_taken && ((state == CS_STALL) || hazard);

    // Outputs are forced to the reset pattern while rst_n is low, independent of the clock.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        pc_sel       = 1'b0;
        ctrl_state   = state;
        if (!rst_n) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            ctrl_state   = CS_RUN;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            ctrl_state   = CS_FREEZE;
        end else if (branch) begin
            pc_sel      = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (stalling) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CS_RUN;
            stall_left <= '0;
        end else if (mem_busy) begin
            state      <= state;
            stall_left <= stall_left;
        end else if (EX_branch_taken) begin
            state      <= CS_RUN;
            stall_left <= '0;
        end else if (state == CS_STALL) begin
            if (stall_left <= STALL_CNT_W'(1)) begin
                state      <= CS_RUN;
                stall_left <= '0;
            end else begin
                stall_left <= stall_left - STALL_CNT_W'(1);
            end
        end else if (hazard && (LOAD_STALL_CYCLES > 1)) begin
            // The hazard cycle itself is the first stall cycle.
            state      <= CS_STALL;
            stall_left <= STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stalling),
        .clr   (1'b0),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (branch),
        .clr   (1'b0),
        .count (flush_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_busy),
        .clr   (1'b0),
        .count (freeze_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed vector bench for pipeline_ctrl, plus a CNT_W=4 instance for saturation.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] ID_rs1, ID_rs2, ID_EX_rd;
    logic       ID_uses_rs2, ID_EX_memread, EX_branch_taken, mem_busy;

    logic        pc_write, IF_ID_write, EX_MEM_write, MEM_WB_write;
    logic        IF_ID_flush, ID_EX_flush, pc_sel;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count, flush_count, freeze_count;

    logic       pc_write4, IF_ID_write4, EX_MEM_write4, MEM_WB_write4;
    logic       IF_ID_flush4, ID_EX_flush4, pc_sel4;
    logic [1:0] ctrl_state4;
    logic [3:0] stall_count4, flush_count4, freeze_count4;

    int total;
    int bad;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs2(ID_uses_rs2),
        .ID_EX_memread(ID_EX_memread), .ID_EX_rd(ID_EX_rd),
        .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .pc_sel(pc_sel), .ctrl_state(ctrl_state),
        .stall_count(stall_count), .flush_count(flush_count), .freeze_count(freeze_count)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs2(ID_uses_rs2),
        .ID_EX_memread(ID_EX_memread), .ID_EX_rd(ID_EX_rd),
        .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write4), .IF_ID_write(IF_ID_write4),
        .EX_MEM_write(EX_MEM_write4), .MEM_WB_write(MEM_WB_write4),
        .IF_ID_flush(IF_ID_flush4), .ID_EX_flush(ID_EX_flush4),
        .pc_sel(pc_sel4), .ctrl_state(ctrl_state4),
        .stall_count(stall_count4), .flush_count(flush_count4), .freeze_count(freeze_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected control word: {pc_write, IF_ID_write, EX_MEM_write, MEM_WB_write,
    //                         IF_ID_flush, ID_EX_flush, pc_sel, ctrl_state[1:0]}
    localparam logic [8:0] NORM  = 9'b1111_000_00;
    localparam logic [8:0] STL0  = 9'b0011_010_00;
    localparam logic [8:0] STL1  = 9'b0011_010_01;
    localparam logic [8:0] FRZ   = 9'b0000_000_10;
    localparam logic [8:0] BR0   = 9'b1111_111_00;
    localparam logic [8:0] RSTO  = 9'b0000_110_00;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic       memread;
        logic [4:0] rd;
        logic       br;
        logic       busy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                                input logic memread, input logic [4:0] rd, input logic br,
                                input logic busy, input logic [8:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.uses = uses; v.memread = memread;
        v.rd = rd; v.br = br; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] ctl_word();
        return {pc_write, IF_ID_write, EX_MEM_write, MEM_WB_write,
                IF_ID_flush, ID_EX_flush, pc_sel, ctrl_state};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_rs1          = v.rs1;
        ID_rs2          = v.rs2;
        ID_uses_rs2     = v.uses;
        ID_EX_memread   = v.memread;
        ID_EX_rd        = v.rd;
        EX_branch_taken = v.br;
        mem_busy        = v.busy;
    endtask

    // Called just after a rising edge; checks mid-cycle and returns just after the next edge.
    task automatic apply(input string name, input vec_t v);
        drive(v);
        @(negedge clk);
        check(name, {23'd0, ctl_word()}, {23'd0, v.exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, NORM));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = mk(5, 0, 0, 0, 5, 0, 0, NORM);  // rd match but not a load
        vecs[1]  = mk(5, 0, 0, 1, 5, 0, 0, STL0);  // load x5 -> use x5
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, STL1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, NORM);
        vecs[4]  = mk(0, 0, 0, 1, 0, 0, 0, NORM);  // x0 never hazards
        vecs[5]  = mk(1, 7, 0, 1, 7, 0, 0, NORM);  // rs2 not read
        vecs[6]  = mk(1, 7, 1, 1, 7, 0, 0, STL0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, STL1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, NORM);
        vecs[9]  = mk(3, 0, 0, 1, 3, 1, 0, BR0);   // branch beats hazard
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, NORM);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, FRZ);
        vecs[12] = mk(4, 0, 0, 1, 4, 0, 1, FRZ);   // freeze beats hazard, stays RUN
        vecs[13] = mk(4, 0, 0, 1, 4, 0, 0, STL0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, FRZ);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, FRZ);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, FRZ);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, STL1);  // stall counter held through freeze
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, NORM);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 1, FRZ);   // freeze beats branch
        vecs[20] = mk(0, 0, 0, 0, 0, 1, 0, BR0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, NORM);

        // Reset state with a live hazard on the inputs.
        drive(mk(5, 5, 1, 1, 5, 0, 0, NORM));
        rst_n = 1'b0;
        #12;
        check("reset_ctl", {23'd0, ctl_word()}, {23'd0, RSTO});
        check("reset_stall_cnt", {16'd0, stall_count}, 32'd0);
        check("reset_flush_cnt", {16'd0, flush_count}, 32'd0);
        check("reset_freeze_cnt", {16'd0, freeze_count}, 32'd0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, NORM));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end
        check("tbl_stall_cnt", {16'd0, stall_count}, 32'd6);
        check("tbl_flush_cnt", {16'd0, flush_count}, 32'd2);
        check("tbl_freeze_cnt", {16'd0, freeze_count}, 32'd6);

        // Isolated load-use stall.
        do_reset();
        apply("lu_c0", mk(5, 0, 0, 1, 5, 0, 0, STL0));
        apply("lu_c1", mk(0, 0, 0, 0, 0, 0, 0, STL1));
        apply("lu_c2", mk(0, 0, 0, 0, 0, 0, 0, NORM));
        check("lu_stall_cnt", {16'd0, stall_count}, 32'd2);

        // Hazard together with a taken branch.
        do_reset();
        apply("hb_c0", mk(9, 9, 1, 1, 9, 1, 0, BR0));
        apply("hb_c1", mk(0, 0, 0, 0, 0, 0, 0, NORM));
        check("hb_flush_cnt", {16'd0, flush_count}, 32'd1);
        check("hb_stall_cnt", {16'd0, stall_count}, 32'd0);

        // Freeze for 3 cycles in the middle of a stall.
        do_reset();
        apply("fz_c0", mk(6, 0, 0, 1, 6, 0, 0, STL0));
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("fz_busy%0d", i), mk(0, 0, 0, 0, 0, 0, 1, FRZ));
        end
        apply("fz_rem", mk(0, 0, 0, 0, 0, 0, 0, STL1));
        apply("fz_done", mk(0, 0, 0, 0, 0, 0, 0, NORM));
        check("fz_freeze_cnt", {16'd0, freeze_count}, 32'd3);
        check("fz_stall_cnt", {16'd0, stall_count}, 32'd2);

        // Reset pulse while in STALL.
        do_reset();
        apply("rs_c0", mk(8, 0, 0, 1, 8, 0, 0, STL0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, NORM));
        rst_n = 1'b0;
        #1;
        check("rs_ctl", {23'd0, ctl_word()}, {23'd0, RSTO});
        check("rs_stall_cnt", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply("rs_after", mk(0, 0, 0, 0, 0, 0, 0, NORM));
        check("rs_stall_cnt_after", {16'd0, stall_count}, 32'd0);

        // Flush counter saturation on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply($sformatf("sat_br%0d", i), mk(0, 0, 0, 0, 0, 1, 0, BR0));
        end
        check("sat_flush_cnt4", {28'd0, flush_count4}, 32'd15);
        check("sat_flush_cnt16", {16'd0, flush_count}, 32'd20);
        apply("sat_idle", mk(0, 0, 0, 0, 0, 0, 0, NORM));
        check("sat_flush_hold4", {28'd0, flush_count4}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
